jt7759_rom_bridge: RTL and testbench

Responder for the jt7759 ROM port. It serves byte reads (rom_cs/rom_addr -> rom_data/rom_ok) from a 16-bit burst memory port, such as the SDRAM controller's ADPCM channel. A single-line read buffer absorbs the chip's mostly sequential access pattern, so that most bytes return one cycle after the address is presented.

---
 rtl/jt7759_pkg.sv | 20 ++
 rtl/jt7759_line_buf.sv | 32 +++
 rtl/jt7759_rom_bridge.sv | 113 +++++++++++
 tb/tb_jt7759_rom_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt7759_pkg.sv
// jt7759 ROM bridge shared types and helpers.
// Line base address forming for burst fetches.
package jt7759_pkg;

  localparam int ROM_AW = 17;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  function automatic logic [31:0] line_base(
    input logic [31:0] tag,
    input int unsigned wb,
    input logic [31:0] offset
  );
    return offset + (tag << wb);
  endfunction

endpackage

// File: rtl/jt7759_line_buf.sv
// Single-line word store for the jt7759 ROM bridge.
// Registered byte-select read port.
module jt7759_line_buf #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(LINE_WORDS)-1:0] waddr,
  input  logic [15:0]                   wdata,
  input  logic                          re,
  input  logic [$clog2(LINE_WORDS)-1:0] raddr,
  input  logic                          bsel,
  output logic [7:0]                    dout
);

  logic [15:0] mem [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (re) begin
      dout <= bsel ? mem[raddr][15:8]
                   : mem[raddr][7:0];
    end
  end

endmodule

// File: rtl/jt7759_rom_bridge.sv
// jt7759 ROM port responder over a 16-bit burst memory.
// One buffered line serves sequential byte reads.
module jt7759_rom_bridge
  import jt7759_pkg::*;
#(
  parameter int               LINE_WORDS = 4,
  parameter int               MEM_AW     = 22,
  parameter logic [MEM_AW-1:0] ROM_OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_cs,
  input  logic [16:0]       rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_ok,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_dok,
  input  logic [15:0]       mem_dout
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int LB = WB + 1;
  localparam int TW = ROM_AW - LB;

  state_t state, state_nxt;

  logic [TW-1:0]     tag, tag_reg;
  logic [WB-1:0]     widx, wcnt;
  logic [ROM_AW-1:0] addr_reg;
  logic              valid, ok_reg, hit;
  logic              rd_en, start, wr_en, last;

  assign tag  = rom_addr[ROM_AW-1:LB];
  assign widx = rom_addr[LB-1:1];
  assign hit  = valid && (tag == tag_reg);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    unique case (state)
      IDLE: begin
        rd_en = rom_cs && hit;
        start = rom_cs && !hit;
      end
      FETCH: wr_en = mem_dok;
      default: ;
    endcase
  end

  // wcnt all-ones marks the final word of a power-of-two line
  assign last = wr_en && (&wcnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      ok_reg   <= 1'b0;
      mem_req  <= 1'b0;
      wcnt     <= '0;
      mem_addr <= '0;
      addr_reg <= '0;
      tag_reg  <= '0;
    end else begin
      ok_reg <= rd_en;
      if (rd_en) addr_reg <= rom_addr;
      if (start) begin
        valid    <= 1'b0;
        tag_reg  <= tag;
        mem_req  <= 1'b1;
        mem_addr <= MEM_AW'(line_base(
                      32'(tag), WB, 32'(ROM_OFFSET)));
      end
      if (wr_en) wcnt <= wcnt + 1'b1;
      if (last) begin
        mem_req <= 1'b0;
        valid   <= 1'b1;
        wcnt    <= '0;
      end
    end
  end

  jt7759_line_buf #(
    .LINE_WORDS(LINE_WORDS)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wcnt),
    .wdata (mem_dout),
    .re    (rd_en),
    .raddr (widx),
    .bsel  (rom_addr[0]),
    .dout  (rom_data)
  );

  assign rom_ok = ok_reg && rom_cs && (rom_addr == addr_reg);

endmodule

// File: tb/tb_jt7759_rom_bridge.sv
// Directed bench for jt7759_rom_bridge.
// Two instances: ROM_OFFSET 0 and 0x100.
module tb_jt7759_rom_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_cs;
  logic [16:0] rom_addr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [21:0] a);
    int b;
    b = int'(a) * 2;
    return {8'(((b + 1) * 17)), 8'((b * 17))};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_dok;
    logic [15:0] mem_dout;
    logic [7:0]  rom_data;
    logic        rom_ok;
    int          nburst;
    int          ndok;
    int          n;
    logic        busy;
    logic        wlow;
    logic [21:0] baddr;

    jt7759_rom_bridge #(
      .LINE_WORDS (4),
      .MEM_AW     (22),
      .ROM_OFFSET (g == 1 ? 22'h100 : 22'h0)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_dok  (mem_dok),
      .mem_dout (mem_dout)
    );

    // memory: one idle cycle, then 4 back-to-back words
    initial begin
      nburst   = 0;
      ndok     = 0;
      n        = 0;
      busy     = 1'b0;
      wlow     = 1'b0;
      baddr    = '0;
      mem_dok  = 1'b0;
      mem_dout = '0;
      forever begin
        @(posedge clk);
        #1;
        mem_dok = 1'b0;
        if (wlow && !mem_req) wlow = 1'b0;
        if (busy) begin
          mem_dok  = 1'b1;
          mem_dout = word(baddr + 22'(n));
          ndok++;
          n++;
          if (n == 4) begin
            busy = 1'b0;
            wlow = 1'b1;
          end
        end else if (mem_req && !wlow) begin
          busy  = 1'b1;
          n     = 0;
          baddr = mem_addr;
          nburst++;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic ok_of(input int g);
    return (g == 0) ? g_mem[0].rom_ok : g_mem[1].rom_ok;
  endfunction

  task automatic wait_ok(input int g, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (ok_of(g)) break;
      cyc();
    end
    chk(tag, 32'(ok_of(g)), 32'd1);
  endtask

  task automatic wait_dok(input int target, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (g_mem[0].ndok >= target) break;
      cyc();
    end
    chk(tag, g_mem[0].ndok, target);
  endtask

  int ld, lat, nb, nd, nd1;

  initial begin
    rst      = 1'b1;
    rom_cs   = 1'b0;
    rom_addr = '0;
    repeat (2) cyc();
    chk("rst_ok",   32'(g_mem[0].rom_ok),   0);
    chk("rst_data", 32'(g_mem[0].rom_data), 0);
    chk("rst_req",  32'(g_mem[0].mem_req),  0);
    rst = 1'b0;
    cyc();

    // 1: cold read
    rom_cs   = 1'b1;
    rom_addr = 17'h00005;
    ld  = -100;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (g_mem[0].mem_dok) ld = i;
      if (g_mem[0].rom_ok) begin
        lat = i - ld;
        break;
      end
    end
    chk("t1_ok",    32'(g_mem[0].rom_ok),   1);
    chk("t1_lat",   lat,                     2);
    chk("t1_data",  32'(g_mem[0].rom_data), 32'h55);
    chk("t1_burst", g_mem[0].nburst,         1);
    chk("t1_addr",  32'(g_mem[0].baddr),    0);
    chk("t1_ndok",  g_mem[0].ndok,           4);

    // 2: sequential hits
    rom_addr = 17'h00006;
    #1;
    chk("t2_stale", 32'(g_mem[0].rom_ok), 0);
    cyc();
    chk("t2_ok6",   32'(g_mem[0].rom_ok),   1);
    chk("t2_d6",    32'(g_mem[0].rom_data), 32'h66);
    rom_addr = 17'h00007;
    cyc();
    cyc();
    chk("t2_ok7",   32'(g_mem[0].rom_ok),   1);
    chk("t2_d7",    32'(g_mem[0].rom_data), 32'h77);
    rom_addr = 17'h00000;
    cyc();
    cyc();
    chk("t2_ok0",   32'(g_mem[0].rom_ok),   1);
    chk("t2_d0",    32'(g_mem[0].rom_data), 32'h00);
    chk("t2_burst", g_mem[0].nburst,         1);

    // 3: next line, offset instance
    nd1 = g_mem[1].ndok;
    rom_addr = 17'h00008;
    cyc();
    chk("t3_req",  32'(g_mem[1].mem_req),  1);
    chk("t3_addr", 32'(g_mem[1].mem_addr), 32'h104);
    chk("t3_a0",   32'(g_mem[0].mem_addr), 32'h4);
    wait_ok(1, "t3_ok");
    chk("t3_ndok", g_mem[1].ndok - nd1,    4);
    chk("t3_data", 32'(g_mem[1].rom_data), 32'h88);

    // 4: stale-ok guard
    rom_addr = 17'h00006;
    cyc();
    wait_ok(0, "t4_ok6");
    rom_addr = 17'h00010;
    #1;
    chk("t4_stale", 32'(g_mem[0].rom_ok), 0);
    cyc();
    chk("t4_req",   32'(g_mem[0].mem_req),  1);
    chk("t4_addr",  32'(g_mem[0].mem_addr), 32'h8);
    wait_ok(0, "t4_ok");
    chk("t4_data",  32'(g_mem[0].rom_data), 32'h10);

    // 5: address change mid-burst
    nb = g_mem[0].nburst;
    nd = g_mem[0].ndok;
    rom_addr = 17'h00020;
    cyc();
    chk("t5_addr0", 32'(g_mem[0].mem_addr), 32'h10);
    wait_dok(nd + 2, "t5_two");
    rom_addr = 17'h00031;
    wait_ok(0, "t5_ok");
    chk("t5_ndok",  g_mem[0].ndok - nd,      8);
    chk("t5_burst", g_mem[0].nburst - nb,    2);
    chk("t5_addr1", 32'(g_mem[0].baddr),    32'h18);
    chk("t5_data",  32'(g_mem[0].rom_data), 32'h41);

    // 6: reset mid-burst
    nd = g_mem[0].ndok;
    rom_addr = 17'h00005;
    cyc();
    wait_dok(nd + 1, "t6_one");
    rst    = 1'b1;
    rom_cs = 1'b0;
    cyc();
    chk("t6_req",  32'(g_mem[0].mem_req),  0);
    chk("t6_ok",   32'(g_mem[0].rom_ok),   0);
    chk("t6_data", 32'(g_mem[0].rom_data), 0);
    rst = 1'b0;
    repeat (8) cyc();
    chk("t6_idle", 32'(g_mem[0].mem_req), 0);
    nb = g_mem[0].nburst;
    rom_cs = 1'b1;
    cyc();
    chk("t6_ok0",  32'(g_mem[0].rom_ok),   0);
    chk("t6_rreq", 32'(g_mem[0].mem_req),  1);
    chk("t6_addr", 32'(g_mem[0].mem_addr), 0);
    wait_ok(0, "t6_okf");
    chk("t6_d",     32'(g_mem[0].rom_data), 32'h55);
    chk("t6_burst", g_mem[0].nburst - nb,   1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
